// File: rtl/vga_sync_monitor.sv
// Passive VGA timing/checksum monitor for the TinyVGA PMOD pinout.
// Measures line/frame periods and sync widths and reports lock on stable frames.
module vga_sync_monitor #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int HW      = 11,
    parameter int VW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic [7:0]    vga_in,
    output logic [HW-1:0] h_total,
    output logic [HW-1:0] h_sync_w,
    output logic [VW-1:0] v_total,
    output logic [VW-1:0] v_sync_w,
    output logic [15:0]   frame_sum,
    output logic          frame_valid,
    output logic [7:0]    frame_count,
    output logic          locked
);

    localparam logic [HW-1:0] H_MAX = '1;
    localparam logic [VW-1:0] V_MAX = '1;
    localparam logic [HW-1:0] H_NOM = HW'(H_TOTAL);
    localparam logic [VW-1:0] V_NOM = VW'(V_TOTAL);
    localparam logic [HW-1:0] H_ONE = HW'(1);
    localparam logic [VW-1:0] V_ONE = VW'(1);

    logic          hs_prev_q, hs_prev_d;
    logic          vs_prev_q, vs_prev_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [HW-1:0] hlow_q, hlow_d;
    logic [VW-1:0] lcnt_q, lcnt_d;
    logic [VW-1:0] vlow_q, vlow_d;
    logic [15:0]   sum_q, sum_d;
    logic          armed_q, armed_d;
    logic          prev_ok_q, prev_ok_d;
    logic [HW-1:0] h_total_q, h_total_d;
    logic [HW-1:0] h_sync_w_q, h_sync_w_d;
    logic [VW-1:0] v_total_q, v_total_d;
    logic [VW-1:0] v_sync_w_q, v_sync_w_d;
    logic [15:0]   frame_sum_q, frame_sum_d;
    logic          frame_valid_q, frame_valid_d;
    logic [7:0]    frame_count_q, frame_count_d;
    logic          locked_q, locked_d;

    logic          hs_s;
    logic          vs_s;
    logic [5:0]    rgb6;
    logic          hs_fall;
    logic          hs_rise;
    logic          vs_fall;
    logic          vs_rise;
    logic [HW-1:0] h_period;
    logic [VW-1:0] v_period;
    logic [HW-1:0] h_now;
    logic          frame_ok;

    // Sample decode and edge detection against the previous strobed sample
    always_comb begin
        hs_s    = vga_in[7];
        vs_s    = vga_in[3];
        rgb6    = {vga_in[0], vga_in[4], vga_in[1],
                   vga_in[5], vga_in[2], vga_in[6]};
        hs_fall = hs_prev_q & ~hs_s;
        hs_rise = ~hs_prev_q & hs_s;
        vs_fall = vs_prev_q & ~vs_s;
        vs_rise = ~vs_prev_q & vs_s;
    end

    // Period of the line ending at this sample, and frame length including it
    always_comb begin
        h_period = hcnt_q;
        if (hcnt_q != H_MAX) begin
            h_period = hcnt_q + H_ONE;
        end
        v_period = lcnt_q;
        if (hs_fall && (lcnt_q != V_MAX)) begin
            v_period = lcnt_q + V_ONE;
        end
        h_now = hs_fall ? h_period : h_total_q;
        frame_ok = (v_period == V_NOM)
                && (h_now == H_NOM)
                && prev_ok_q
                && (sum_q == frame_sum_q);
    end

    always_comb begin
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        hcnt_d        = hcnt_q;
        hlow_d        = hlow_q;
        lcnt_d        = lcnt_q;
        vlow_d        = vlow_q;
        sum_d         = sum_q;
        armed_d       = armed_q;
        prev_ok_d     = prev_ok_q;
        h_total_d     = h_total_q;
        h_sync_w_d    = h_sync_w_q;
        v_total_d     = v_total_q;
        v_sync_w_d    = v_sync_w_q;
        frame_sum_d   = frame_sum_q;
        frame_valid_d = 1'b0;
        frame_count_d = frame_count_q;
        locked_d      = locked_q;

        if (pix_en) begin
            hs_prev_d = hs_s;
            vs_prev_d = vs_s;

            if (hs_fall) begin
                h_total_d = h_period;
                hcnt_d    = '0;
            end else if (hcnt_q != H_MAX) begin
                hcnt_d = hcnt_q + H_ONE;
            end

            if (hs_fall) begin
                hlow_d = H_ONE;
            end else if (!hs_s && (hlow_q != H_MAX)) begin
                hlow_d = hlow_q + H_ONE;
            end
            if (hs_rise) begin
                h_sync_w_d = hlow_q;
            end

            if (vs_fall) begin
                lcnt_d = '0;
            end else if (hs_fall && (lcnt_q != V_MAX)) begin
                lcnt_d = lcnt_q + V_ONE;
            end

            // VS width is counted in HS falls, including one coincident with the VS fall
            if (vs_fall) begin
                vlow_d = {{(VW-1){1'b0}}, hs_fall};
            end else if (hs_fall && !vs_s && (vlow_q != V_MAX)) begin
                vlow_d = vlow_q + V_ONE;
            end
            if (vs_rise) begin
                v_sync_w_d = vlow_q;
            end

            if (vs_fall) begin
                sum_d = {10'b0, rgb6};
            end else begin
                sum_d = {sum_q[14:0], sum_q[15]} ^ {10'b0, rgb6};
            end

            if (vs_fall) begin
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else begin
                    frame_sum_d   = sum_q;
                    v_total_d     = v_period;
                    frame_valid_d = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                    prev_ok_d     = 1'b1;
                    locked_d      = frame_ok;
                end
            end

            if (hs_fall && (h_period != H_NOM)) begin
                locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            hcnt_q        <= '0;
            hlow_q        <= '0;
            lcnt_q        <= '0;
            vlow_q        <= '0;
            sum_q         <= '0;
            armed_q       <= 1'b0;
            prev_ok_q     <= 1'b0;
            h_total_q     <= '0;
            h_sync_w_q    <= '0;
            v_total_q     <= '0;
            v_sync_w_q    <= '0;
            frame_sum_q   <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            locked_q      <= 1'b0;
        end else begin
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            hcnt_q        <= hcnt_d;
            hlow_q        <= hlow_d;
            lcnt_q        <= lcnt_d;
            vlow_q        <= vlow_d;
            sum_q         <= sum_d;
            armed_q       <= armed_d;
            prev_ok_q     <= prev_ok_d;
            h_total_q     <= h_total_d;
            h_sync_w_q    <= h_sync_w_d;
            v_total_q     <= v_total_d;
            v_sync_w_q    <= v_sync_w_d;
            frame_sum_q   <= frame_sum_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            locked_q      <= locked_d;
        end
    end

    assign h_total     = h_total_q;
    assign h_sync_w    = h_sync_w_q;
    assign v_total     = v_total_q;
    assign v_sync_w    = v_sync_w_q;
    assign frame_sum   = frame_sum_q;
    assign frame_valid = frame_valid_q;
    assign frame_count = frame_count_q;
    assign locked      = locked_q;

endmodule
